// File: rtl/adc_capture_pkg.sv
// Shared constants and helpers for the dual-channel ADC capture block:
// decimation limit, offset-binary flip mask and full-scale code generation.
package adc_capture_pkg;

  localparam int DECIM_LOG2_MAX = 4;
  localparam int WIDTH_MAX      = 16;

  // XOR mask that turns an offset-binary code into two's complement (MSB flip).
  function automatic logic [WIDTH_MAX-1:0] ob_flip_mask(input int w, input bit offset_bin);
    logic [WIDTH_MAX-1:0] m;
    m = '0;
    if (offset_bin) m[4'(w - 1)] = 1'b1;
    return m;
  endfunction

  function automatic logic [WIDTH_MAX-1:0] fs_pos(input int w);
    return (16'd1 << (w - 1)) - 16'd1;
  endfunction

  function automatic logic [WIDTH_MAX-1:0] fs_neg(input int w);
    return 16'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/adc_decim_acc.sv
// Per-channel window accumulator: sums qualified samples and, on dump,
// loads the arithmetic-shifted average into a held result register.
module adc_decim_acc
  import adc_capture_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int DECIM_LOG2 = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    add_i,
  input  logic                    dump_i,
  input  logic signed [WIDTH-1:0] smp_i,
  output logic        [WIDTH-1:0] res_o
);

  localparam int AW = WIDTH + DECIM_LOG2;

  logic signed [AW-1:0]    sum_q, sum_d;
  logic        [WIDTH-1:0] res_q, res_d;

  // The completing sample is folded in before the shift, so dump sees the full window.
  always_comb begin
    sum_d = sum_q;
    if (add_i) sum_d = sum_q + AW'(smp_i);
    res_d = res_q;
    if (dump_i) res_d = WIDTH'(sum_d >>> DECIM_LOG2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      res_q <= '0;
    end else begin
      res_q <= res_d;
      sum_q <= dump_i ? '0 : sum_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/adc_dual_capture.sv
// Dual-channel ADC capture: mux/parallel input capture, offset-binary conversion,
// 2^DECIM_LOG2 averaging. Optional sticky full-scale flags via ADC_CAPTURE_OVR_EN.
module adc_dual_capture
  import adc_capture_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int MUX        = 1,
  parameter int OFFSET_BIN = 0,
  parameter int DECIM_LOG2 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] di_a,
  input  logic [WIDTH-1:0] di_b,
  output logic [WIDTH-1:0] dao,
  output logic [WIDTH-1:0] dbo,
  output logic             valid,
  output logic             ovr_a,
  output logic             ovr_b,
  input  logic             ovr_clr
);

  // valid is a one-cycle strobe with no backpressure; dao/dbo are stable until the next strobe.
  localparam int                 CW     = DECIM_LOG2 + 1;
  localparam logic [CW-1:0]      LAST   = CW'((1 << DECIM_LOG2) - 1);
  localparam logic [15:0]        FLIP16 = ob_flip_mask(WIDTH, OFFSET_BIN != 0);
  localparam logic [WIDTH-1:0]   FLIP   = FLIP16[WIDTH-1:0];

  logic [WIDTH-1:0] cap_a, cap_b;

  if (MUX != 0) begin : g_mux
    logic [WIDTH-1:0] hold_a_q;
    logic             unused_di_b;
    // A is presented on the falling edge; hold it until the B half arrives.
    always_ff @(negedge clk or posedge rst) begin
      if (rst) hold_a_q <= '0;
      else     hold_a_q <= di_a;
    end
    assign cap_a       = hold_a_q;
    assign cap_b       = di_a;
    assign unused_di_b = ^di_b;
  end else begin : g_par
    assign cap_a = di_a;
    assign cap_b = di_b;
  end

  logic [WIDTH-1:0] s1_a_q, s1_b_q, s2_a_q, s2_b_q;
  logic             s1_en_q, s2_en_q, valid_q;
  logic [CW-1:0]    cnt_q;
  logic             dump;

  assign dump = s2_en_q && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_en_q <= 1'b0;
      s2_a_q  <= '0;
      s2_b_q  <= '0;
      s2_en_q <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      s1_a_q  <= cap_a;
      s1_b_q  <= cap_b;
      s1_en_q <= en;
      s2_a_q  <= s1_a_q ^ FLIP;
      s2_b_q  <= s1_b_q ^ FLIP;
      s2_en_q <= s1_en_q;
      valid_q <= dump;
      if (s2_en_q) cnt_q <= dump ? '0 : cnt_q + 1'b1;
    end
  end

  adc_decim_acc #(.WIDTH(WIDTH), .DECIM_LOG2(DECIM_LOG2)) u_acc_a (
    .clk(clk), .rst(rst), .add_i(s2_en_q), .dump_i(dump), .smp_i(s2_a_q), .res_o(dao)
  );

  adc_decim_acc #(.WIDTH(WIDTH), .DECIM_LOG2(DECIM_LOG2)) u_acc_b (
    .clk(clk), .rst(rst), .add_i(s2_en_q), .dump_i(dump), .smp_i(s2_b_q), .res_o(dbo)
  );

  assign valid = valid_q;

`ifdef ADC_CAPTURE_OVR_EN
  localparam logic [15:0]      POS16  = fs_pos(WIDTH);
  localparam logic [15:0]      NEG16  = fs_neg(WIDTH);
  localparam logic [WIDTH-1:0] FS_POS = POS16[WIDTH-1:0];
  localparam logic [WIDTH-1:0] FS_NEG = NEG16[WIDTH-1:0];

  logic ovr_a_q, ovr_b_q, hit_a, hit_b;

  assign hit_a = s2_en_q && (s2_a_q == FS_POS || s2_a_q == FS_NEG);
  assign hit_b = s2_en_q && (s2_b_q == FS_POS || s2_b_q == FS_NEG);

  // A new full-scale hit outranks a clear issued in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_a_q <= 1'b0;
      ovr_b_q <= 1'b0;
    end else begin
      ovr_a_q <= hit_a ? 1'b1 : (ovr_clr ? 1'b0 : ovr_a_q);
      ovr_b_q <= hit_b ? 1'b1 : (ovr_clr ? 1'b0 : ovr_b_q);
    end
  end

  assign ovr_a = ovr_a_q;
  assign ovr_b = ovr_b_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = ovr_clr;
  assign ovr_a          = 1'b0;
  assign ovr_b          = 1'b0;
`endif

endmodule

// File: tb/tb_adc_dual_capture.sv
// Bench for adc_dual_capture: a muxed two's-complement instance (no averaging)
// and a parallel offset-binary instance averaging over 4, checked by a scoreboard.
module tb_adc_dual_capture;

  localparam int W  = 12;
  localparam int D1 = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, ovr_clr = 1'b0;
  logic [W-1:0] di_a0 = '0, di_b0 = '0, di_a1 = '0, di_b1 = '0;
  logic [W-1:0] dao0, dbo0, dao1, dbo1;
  logic valid0, valid1, ovr_a0, ovr_b0, ovr_a1, ovr_b1;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_dual_capture #(.WIDTH(W), .MUX(1), .OFFSET_BIN(0), .DECIM_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .di_a(di_a0), .di_b(di_b0), .dao(dao0), .dbo(dbo0),
    .valid(valid0), .ovr_a(ovr_a0), .ovr_b(ovr_b0), .ovr_clr(ovr_clr)
  );

  adc_dual_capture #(.WIDTH(W), .MUX(0), .OFFSET_BIN(1), .DECIM_LOG2(D1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .di_a(di_a1), .di_b(di_b1), .dao(dao1), .dbo(dbo1),
    .valid(valid1), .ovr_a(ovr_a1), .ovr_b(ovr_b1), .ovr_clr(ovr_clr)
  );

  // scoreboard state: entries are {cycle, a, b}
  logic [63:0] exp0_q[$], exp1_q[$];
  int tests = 0, errs = 0;
  int sum_a[2], sum_b[2], cnt[2];
  logic [W-1:0] last_a[2], last_b[2];
  bit hit_a[2][int], hit_b[2][int], clr_at[int];
  bit exp_oa[2], exp_ob[2];

  function automatic int win(input int d);
    return (d == 0) ? 1 : (1 << D1);
  endfunction

  function automatic int rv();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -2048;
    if (r == 1) return 2047;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic bit fs(input int v);
    return (v == -2048) || (v == 2047);
  endfunction

  task automatic model_add(input int d, input int cap, input int a, input int b);
    logic [63:0] e;
    if (fs(a)) hit_a[d][cap + 2] = 1'b1;
    if (fs(b)) hit_b[d][cap + 2] = 1'b1;
    sum_a[d] += a;
    sum_b[d] += b;
    cnt[d]++;
    if (cnt[d] == win(d)) begin
      e = {32'(cap + 2), 16'(sum_a[d] / win(d) - ((sum_a[d] % win(d) < 0) ? 1 : 0)),
           16'(sum_b[d] / win(d) - ((sum_b[d] % win(d) < 0) ? 1 : 0))};
      if (d == 0) exp0_q.push_back(e);
      else        exp1_q.push_back(e);
      sum_a[d] = 0; sum_b[d] = 0; cnt[d] = 0;
    end
  endtask

  task automatic model_clear();
    exp0_q.delete(); exp1_q.delete(); clr_at.delete();
    for (int d = 0; d < 2; d++) begin
      sum_a[d] = 0; sum_b[d] = 0; cnt[d] = 0;
      last_a[d] = '0; last_b[d] = '0;
      exp_oa[d] = 1'b0; exp_ob[d] = 1'b0;
      hit_a[d].delete(); hit_b[d].delete();
    end
  endtask

  // driver: called at posedge+1; values are signed sample values
  task automatic step(input int a0, input int b0, input int a1, input int b1,
                      input bit e, input bit c);
    int cap;
    cap = cyc + 1;
    en = e; ovr_clr = c;
    di_a0 = W'(a0);
    di_b0 = W'($urandom);
    di_a1 = W'(a1 + 2048);
    di_b1 = W'(b1 + 2048);
    clr_at[cap] = c;
    if (e) begin
      model_add(0, cap, a0, b0);
      model_add(1, cap, a1, b1);
    end
    @(negedge clk);
    #1 di_a0 = W'(b0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ovr_clr = 1'b0;
    #1;
    model_clear();
    chk("rst_dao0", dao0, '0);     chk("rst_dbo0", dbo0, '0);
    chk("rst_dao1", dao1, '0);     chk("rst_dbo1", dbo1, '0);
    chk("rst_valid", W'({valid0, valid1}), '0);
    chk("rst_ovr", W'({ovr_a0, ovr_b0, ovr_a1, ovr_b1}), '0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // monitor
  task automatic check_out(input int d, input logic v, input logic [W-1:0] da,
                           input logic [W-1:0] db, input logic oa, input logic ob);
    logic [63:0] e;
    int n;
    n = (d == 0) ? exp0_q.size() : exp1_q.size();
    if (v) begin
      if (n == 0) begin
        tests++; errs++;
        $display("FAIL valid%0d: strobe at cycle %0d, none expected", d, cyc);
      end else begin
        if (d == 0) e = exp0_q.pop_front();
        else        e = exp1_q.pop_front();
        chk($sformatf("latency%0d", d), W'(cyc), W'(int'(e[63:32])));
        chk($sformatf("dao%0d", d), da, e[W+15:16]);
        chk($sformatf("dbo%0d", d), db, e[W-1:0]);
        last_a[d] = e[W+15:16];
        last_b[d] = e[W-1:0];
      end
    end else begin
      chk($sformatf("hold_dao%0d", d), da, last_a[d]);
      chk($sformatf("hold_dbo%0d", d), db, last_b[d]);
      if (n > 0) begin
        e = (d == 0) ? exp0_q[0] : exp1_q[0];
        if (int'(e[63:32]) <= cyc) begin
          tests++; errs++;
          $display("FAIL missing%0d: no strobe at cycle %0d expected %0d", d, cyc, int'(e[63:32]));
          if (d == 0) void'(exp0_q.pop_front());
          else        void'(exp1_q.pop_front());
        end
      end
    end
`ifdef ADC_CAPTURE_OVR_EN
    if (hit_a[d].exists(cyc)) exp_oa[d] = 1'b1;
    else if (clr_at.exists(cyc) && clr_at[cyc]) exp_oa[d] = 1'b0;
    if (hit_b[d].exists(cyc)) exp_ob[d] = 1'b1;
    else if (clr_at.exists(cyc) && clr_at[cyc]) exp_ob[d] = 1'b0;
`endif
    chk($sformatf("ovr_a%0d", d), W'(oa), W'(exp_oa[d]));
    chk($sformatf("ovr_b%0d", d), W'(ob), W'(exp_ob[d]));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_out(0, valid0, dao0, dbo0, ovr_a0, ovr_b0);
      check_out(1, valid1, dao1, dbo1, ovr_a1, ovr_b1);
    end
  end

  initial begin
    model_clear();
    @(posedge clk);
    #1 do_reset();

    // muxed capture of 0x123/0x456; offset-binary 0x800/0x000 inputs
    step('h123, 'h456, 10, -2048, 1'b1, 1'b0);
    step(-5, 7, 11, -2048, 1'b1, 1'b0);
    step(100, -100, 12, -2048, 1'b1, 1'b0);
    step(0, 1, -1, -2048, 1'b1, 1'b0);
    // averaging with negative truncation, gated samples mid-window
    step(1, 2, -1, 0, 1'b1, 1'b0);
    step(3, 4, -1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(rv(), rv(), rv(), rv(), 1'b0, 1'b0);
    step(5, 6, -1, 0, 1'b1, 1'b0);
    step(7, 8, -2, 0, 1'b1, 1'b0);
    // full-scale flags, clear with concurrent full-scale, clear alone
    step(0, 0, 0, 2047, 1'b1, 1'b0);
    step(0, 0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 0, -2048, 1'b1, 1'b1);
    step(0, 0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 1'b0, 1'b0);
    step(0, 0, 0, 1, 1'b1, 1'b1);
    step(0, 0, 0, 1, 1'b1, 1'b0);
    // reset mid-window after 3 of 4 samples
    for (int i = 0; i < 3; i++) step(rv(), rv(), 500, 600, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(rv(), rv(), -7, 9, 1'b1, 1'b0);

    for (int i = 0; i < 900; i++) begin
      if (i == 300 || i == 650) do_reset();
      step(rv(), rv(), rv(), rv(), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1'b0, 1'b0);

    chk("drain0", W'(exp0_q.size()), '0);
    chk("drain1", W'(exp1_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
